fetch_sequencer: RTL and testbench

//   Sequences instruction-memory reads for the IF stage over a req/ready + rvalid handshake.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_buffer.sv | 60 ++++++
 rtl/fetch_sequencer.sv | 151 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the instruction fetch path.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {pc, instr} pairs with a single-cycle flush.
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic                       head_valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    // Flush wins over both ends; guards keep the pointers sane even if a caller misbehaves.
    assign do_push = push & ~flush & (count != CW'(DEPTH));
    assign do_pop  = pop  & ~flush & (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head       = mem[rd_ptr];
    assign head_valid = (count != '0);

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage fetch sequencer: one outstanding read over req/ready + rvalid, prefetch buffer toward ID,
// with ID stall and redirect handling.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_flag_id,
    input  logic [31:0] jump_address_id,
    input  logic        stall_id,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instruction_valid,
    output logic [31:0] instruction,
    output logic [31:0] instruction_address
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t  state;
    fetch_state_t  state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_next;
    logic [31:0]   req_pc;
    logic [31:0]   jump_target;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          accept;
    logic          outstanding;
    logic          credit_idle;
    logic          credit_overlap;
    logic          unused_jump_bits;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;
    logic          head_valid;

    assign jump_target      = {jump_address_id[31:2], 2'b00};
    assign unused_jump_bits = &{1'b0, jump_address_id[1:0]};

    assign pop         = head_valid & ~stall_id & ~jump_flag_id;
    assign accept      = imem_req & imem_ready;
    assign outstanding = (state == WAIT) || (state == DROP);
    assign imem_addr   = fetch_pc;

    // Overlap credit: after this cycle's push and pop, a new read must still leave room for its data.
    assign credit_idle    = (count < CW'(BUF_DEPTH));
    assign credit_overlap = ((count - CW'(pop)) < CW'(BUF_DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            if (accept) begin
                req_pc <= fetch_pc;
            end
        end
    end

    // WAIT may issue the next read in the cycle its data returns, giving one instruction per cycle.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        imem_req      = 1'b0;
        push          = 1'b0;
        case (state)
            IDLE: begin
                if (credit_idle) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    state_next    = WAIT;
                    fetch_pc_next = fetch_pc + 32'd4;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push = 1'b1;
                    if (credit_overlap) begin
                        imem_req = 1'b1;
                        if (imem_ready) begin
                            fetch_pc_next = fetch_pc + 32'd4;
                        end else begin
                            state_next = REQ;
                        end
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A redirect discards any returning data and must drop a read that is still in flight.
        if (jump_flag_id) begin
            push          = 1'b0;
            fetch_pc_next = jump_target;
            if (state == WAIT) begin
                imem_req = 1'b0;
            end
            if ((imem_req && imem_ready) || (outstanding && !imem_rvalid)) begin
                state_next = DROP;
            end else begin
                state_next = REQ;
            end
        end
    end

    assign push_entry.pc    = req_pc;
    assign push_entry.instr = imem_rdata;

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (jump_flag_id),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .head       (head),
        .head_valid (head_valid),
        .count      (count)
    );

    assign instruction_valid   = head_valid;
    assign instruction         = head_valid ? head.instr : NOP_INSTR;
    assign instruction_address = head_valid ? head.pc : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer with a behavioural variable-latency instruction memory.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        jump_flag_id;
    logic [31:0] jump_address_id;
    logic        stall_id;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instruction_valid;
    logic [31:0] instruction;
    logic [31:0] instruction_address;

    logic        ready_en;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stray;
    int          lat;
    int          cyc;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    logic [31:0] acc_log[$];
    logic [31:0] exp_q[$];
    int          pop_cyc[$];

    int checks;
    int passes;
    int mark;
    int n;
    int n20;

    fetch_sequencer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .jump_flag_id        (jump_flag_id),
        .jump_address_id     (jump_address_id),
        .stall_id            (stall_id),
        .imem_req            (imem_req),
        .imem_addr           (imem_addr),
        .imem_ready          (imem_ready),
        .imem_rvalid         (imem_rvalid),
        .imem_rdata          (imem_rdata),
        .instruction_valid   (instruction_valid),
        .instruction         (instruction),
        .instruction_address (instruction_address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_ready  = ready_en;
    assign imem_rvalid = mem_rvalid | stray;
    assign imem_rdata  = stray ? 32'hDEAD_BEEF : mem_rdata;

    function automatic logic [31:0] instr_of(logic [31:0] pc);
        return (pc << 8) ^ 32'h5A00_0033;
    endfunction

    task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(logic jump, logic [31:0] addr, logic stall);
        jump_flag_id    = jump;
        jump_address_id = addr;
        stall_id        = stall;
    endtask

    task automatic redirect(logic [31:0] addr, logic stall);
        apply_stimulus(1'b1, addr, stall);
        tick();
        jump_flag_id = 1'b0;
    endtask

    task automatic drain(string name, int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check_output({name, "_drained_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset(string tag);
        check_output({tag, "_imem_req"}, {31'd0, imem_req}, 32'd0);
        check_output({tag, "_imem_addr"}, imem_addr, 32'h0);
        check_output({tag, "_valid"}, {31'd0, instruction_valid}, 32'd0);
        check_output({tag, "_instruction"}, instruction, 32'h0000_0013);
        check_output({tag, "_instr_addr"}, instruction_address, 32'h0);
    endtask

    // Memory: responds lat cycles after accept, in order, with a pc-derived word.
    always @(posedge clk) begin
        #1;
        cyc        = cyc + 1;
        mem_rvalid = 1'b0;
        if (!rst_n) begin
            pend_q.delete();
        end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = instr_of(pend_q[0].addr);
            void'(pend_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && imem_req && imem_ready) begin
            acc_log.push_back(imem_addr);
            pend_q.push_back('{imem_addr, cyc + lat});
        end
    end

    // Monitor: compares the presented head with the scoreboard and retires it when ID consumes it.
    always @(negedge clk) begin
        if (rst_n && instruction_valid && !jump_flag_id) begin
            if (exp_q.size() > 0) begin
                check_output("head_pc", instruction_address, exp_q[0]);
                check_output("head_instr", instruction, instr_of(exp_q[0]));
                if (!stall_id) begin
                    void'(exp_q.pop_front());
                    pop_cyc.push_back(cyc);
                end
            end else if (!stall_id) begin
                check_output("unexpected_pop_pc", instruction_address, 32'hFFFF_FFFF);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks     = 0;
        passes     = 0;
        cyc        = 0;
        lat        = 1;
        ready_en   = 1'b1;
        stray      = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        rst_n      = 1'b0;
        apply_stimulus(1'b0, 32'h0, 1'b1);
        repeat (3) tick();
        check_reset("reset");

        $display("[TB] streaming from RESET_PC with zero-wait memory");
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        pop_cyc.delete();
        rst_n    = 1'b1;
        stall_id = 1'b0;
        drain("t1", 40);
        stall_id = 1'b1;
        check_output("t1_pop_count", 32'(pop_cyc.size()), 32'd8);
        check_output("t1_back_to_back",
                     (pop_cyc.size() == 8) ? 32'(pop_cyc[7] - pop_cyc[0]) : 32'hFFFF_FFFF, 32'd7);

        $display("[TB] ID stall with full buffer");
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output("t2_head_stable", instruction_address, 32'h20);
        end
        check_output("t2_req_dropped", {31'd0, imem_req}, 32'd0);
        check_output("t2_valid_held", {31'd0, instruction_valid}, 32'd1);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h20 + 32'(i * 4));
        stall_id = 1'b0;
        drain("t2", 40);
        stall_id = 1'b1;

        $display("[TB] redirect with full buffer, then redirect while waiting");
        repeat (8) tick();
        lat = 4;
        exp_q.delete();
        redirect(32'h203, 1'b1);
        check_output("t4_valid_flushed", {31'd0, instruction_valid}, 32'd0);
        check_output("t4_nop", instruction, 32'h0000_0013);
        check_output("t4_addr_zero", instruction_address, 32'h0);
        check_output("t4_imem_addr", imem_addr, 32'h200);
        check_output("t4_imem_req", {31'd0, imem_req}, 32'd1);
        tick();
        mark = acc_log.size();
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h100 + 32'(i * 4));
        redirect(32'h100, 1'b0);
        drain("t3", 80);
        stall_id = 1'b1;
        check_output("t3_first_accept",
                     (acc_log.size() > mark) ? acc_log[mark] : 32'hFFFF_FFFF, 32'h100);

        $display("[TB] redirect while request held by ready=0");
        repeat (20) tick();
        lat      = 1;
        ready_en = 1'b0;
        redirect(32'h20, 1'b1);
        check_output("t5_req_held", {31'd0, imem_req}, 32'd1);
        check_output("t5_addr_0x20", imem_addr, 32'h20);
        mark = acc_log.size();
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h44);
        tick();
        redirect(32'h40, 1'b0);
        check_output("t5_addr_switched", imem_addr, 32'h40);
        tick();
        ready_en = 1'b1;
        drain("t5", 40);
        stall_id = 1'b1;
        check_output("t5_first_accept",
                     (acc_log.size() > mark) ? acc_log[mark] : 32'hFFFF_FFFF, 32'h40);
        n20 = 0;
        for (int i = mark; i < acc_log.size(); i++) begin
            if (acc_log[i] == 32'h20) n20++;
        end
        check_output("t5_0x20_accepts", 32'(n20), 32'd0);

        $display("[TB] reset during an outstanding read");
        repeat (10) tick();
        lat = 4;
        redirect(32'h80, 1'b1);
        mark = acc_log.size();
        n    = 0;
        while (acc_log.size() == mark && n < 20) begin
            tick();
            n++;
        end
        check_output("t6_accept_seen", 32'(acc_log.size() - mark), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset("t6_reset");
        tick();
        tick();
        exp_q.delete();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        mark     = acc_log.size();
        lat      = 1;
        stray    = 1'b1;
        rst_n    = 1'b1;
        stall_id = 1'b0;
        tick();
        stray = 1'b0;
        check_output("t6_stray_ignored", {31'd0, instruction_valid}, 32'd0);
        drain("t6", 40);
        check_output("t6_first_fetch",
                     (acc_log.size() > mark) ? acc_log[mark] : 32'hFFFF_FFFF, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
